sram_burst_seq: RTL and testbench

Burst sequencer that sits directly upstream of the SRAM controller in the MNIST datapath. Accepts read or write burst requests (start address plus length) from the layer engines. Breaks each burst into single-word accesses with the controller's required enable/read/write hold times and inter-access gaps, auto-incrementing the address. Streams write data in through a valid/ready handshake and returns read data as one-cycle valid pulses.

---
 rtl/sram_burst_seq.sv | 191 +++++++++++++++++++
 tb/tb_sram_burst_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_seq.sv
`default_nettype none
// ============================================================================
// Module  : sram_burst_seq
// Purpose : Burst sequencer in front of the SRAM controller. Accepts read or
//           write burst requests (start address + length), splits each burst
//           into single-word accesses with fixed enable/strobe hold times and
//           a one-cycle gap, auto-incrementing (and wrapping) the address.
//           Write words arrive over a valid/ready handshake; read words are
//           returned as one-cycle rd_valid pulses.
// Ports   : clk, rst_n                       clock, async active-low reset
//           req_valid/req_ready/req_write/req_addr/req_len  burst request
//           wr_valid/wr_ready/wr_data        write-data stream
//           rd_valid/rd_data                 read-data pulses
//           done, busy                       burst status
//           ctrl_en/ctrl_write/ctrl_read/ctrl_addr/ctrl_data_in/ctrl_data_out
//                                            SRAM controller side
// Revision: 1.0  initial release
// ============================================================================
module sram_burst_seq #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int WR_CYC = 2,
  parameter int RD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              ctrl_en,
  output logic              ctrl_write,
  output logic              ctrl_read,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_data_in,
  input  logic [DATA_W-1:0] ctrl_data_out
);

  // Hold counter runs 0..N-1 across a WRITE/READ dwell, so clog2 of the
  // longer dwell is enough bits (minimum one).
  localparam int c_hold_max = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int c_hold_w   = (c_hold_max > 1) ? $clog2(c_hold_max) : 1;
  localparam logic [c_hold_w-1:0] c_wr_last = c_hold_w'(WR_CYC - 1);
  localparam logic [c_hold_w-1:0] c_rd_last = c_hold_w'(RD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_READ  = 3'd4,
    ST_CAP   = 3'd5
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [c_hold_w-1:0] r_hold,      w_hold_nxt;
  logic [ADDR_W-1:0]   r_cur_addr,  w_cur_addr_nxt;
  logic [LEN_W-1:0]    r_remaining, w_remaining_nxt;
  logic [DATA_W-1:0]   r_data_in,   w_data_in_nxt;
  logic [DATA_W-1:0]   r_rd_data,   w_rd_data_nxt;
  logic                r_rd_valid,  w_rd_valid_nxt;
  logic                r_done,      w_done_nxt;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_data_in   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_data_in   <= w_data_in_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_data_in_nxt   = r_data_in;
    w_rd_data_nxt   = r_rd_data;
    w_rd_valid_nxt  = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cur_addr_nxt  = req_addr;
          w_remaining_nxt = req_len;
          w_hold_nxt      = '0;
          w_state_nxt     = req_write ? ST_WDATA : ST_READ;
        end
      end

      ST_WDATA: begin
        if (wr_valid) begin
          w_data_in_nxt = wr_data;
          w_hold_nxt    = '0;
          w_state_nxt   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (r_hold == c_wr_last) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      // Address advances on leaving the gap so ctrl_addr stays put for the
      // whole word including its gap cycle.
      ST_GAP: begin
        w_cur_addr_nxt = r_cur_addr + 1'b1;
        if (r_remaining == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_remaining_nxt = r_remaining - 1'b1;
          w_state_nxt     = ST_WDATA;
        end
      end

      ST_READ: begin
        if (r_hold == c_rd_last) begin
          w_state_nxt = ST_CAP;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      // The controller has already latched the word on the negedge during
      // READ, so ctrl_data_out is settled throughout CAP.
      ST_CAP: begin
        w_rd_data_nxt  = ctrl_data_out;
        w_rd_valid_nxt = 1'b1;
        w_cur_addr_nxt = r_cur_addr + 1'b1;
        if (r_remaining == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_remaining_nxt = r_remaining - 1'b1;
          w_hold_nxt      = '0;
          w_state_nxt     = ST_READ;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: decoded from the state register or driven straight from
  // registers, so nothing on the port side depends combinationally on inputs.
  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign wr_ready     = (r_state == ST_WDATA);
  assign ctrl_write   = (r_state == ST_WRITE);
  assign ctrl_read    = (r_state == ST_READ);
  assign ctrl_en      = ctrl_write | ctrl_read;
  assign ctrl_addr    = r_cur_addr;
  assign ctrl_data_in = r_data_in;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_burst_seq
// Purpose : Directed self-checking bench for sram_burst_seq. Read data is
//           scoreboarded: expected words are queued when a read burst is
//           issued and popped by a monitor on every rd_valid pulse.
// Revision: 1.0  initial release
// ============================================================================
module tb_sram_burst_seq;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              busy;
  logic              ctrl_en;
  logic              ctrl_write;
  logic              ctrl_read;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_data_in;
  logic [DATA_W-1:0] ctrl_data_out;

  logic              rd_override;
  logic [DATA_W-1:0] rd_override_val;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] rd_q[$];

  always #5 clk = ~clk;

  sram_burst_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WR_CYC(2), .RD_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .busy(busy),
    .ctrl_en(ctrl_en), .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
    .ctrl_addr(ctrl_addr), .ctrl_data_in(ctrl_data_in),
    .ctrl_data_out(ctrl_data_out)
  );

  // SRAM model: each address returns a fixed pattern unless overridden.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {13'd0, a[18:16]} ^ 16'h5A3C;
  endfunction

  assign ctrl_data_out = rd_override ? rd_override_val : pat(ctrl_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request is presented now and handshakes at the next edge E; returns in C(E).
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_reads(input logic [ADDR_W-1:0] a, input int words);
    logic [ADDR_W-1:0] ad;
    ad = a;
    for (int k = 0; k < words; k++) begin
      rd_q.push_back(rd_override ? rd_override_val : pat(ad));
      ad = ad + 1'b1;
    end
  endtask

  // Scoreboard monitor plus strobe-exclusivity check.
  always begin
    @(posedge clk);
    #1;
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_data", {16'd0, rd_data}, {16'd0, rd_q.pop_front()});
      end
    end
    if (ctrl_write || ctrl_read) begin
      chk("strobe_exclusive", {31'd0, ctrl_write & ctrl_read}, 32'd0);
      chk("strobe_en", {31'd0, ctrl_en}, 32'd1);
    end
  end

  initial begin
    logic [ADDR_W-1:0] ea;
    int pulses;
    logic [ADDR_W-1:0] last_addr;
    logic seen_done;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    rd_override = 1'b0; rd_override_val = '0;
    step(); step();

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ctrl_en", {31'd0, ctrl_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_ctrl_addr", {13'd0, ctrl_addr}, 32'd0);
    chk("rst_ctrl_data_in", {16'd0, ctrl_data_in}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single read
    rd_override = 1'b1; rd_override_val = 16'hBEEF;
    push_reads(19'h00010, 1);
    issue(1'b0, 19'h00010, 8'd0);
    chk("r1_read_c0", {31'd0, ctrl_read}, 32'd1);
    chk("r1_addr_c0", {13'd0, ctrl_addr}, 32'h10);
    chk("r1_req_ready_c0", {31'd0, req_ready}, 32'd0);
    step();
    chk("r1_read_c1", {31'd0, ctrl_read}, 32'd1);
    chk("r1_addr_c1", {13'd0, ctrl_addr}, 32'h10);
    step();
    chk("r1_read_c2", {31'd0, ctrl_read}, 32'd0);
    chk("r1_done_c2", {31'd0, done}, 32'd0);
    step();
    chk("r1_rd_valid_c3", {31'd0, rd_valid}, 32'd1);
    chk("r1_done_c3", {31'd0, done}, 32'd1);
    chk("r1_req_ready_c3", {31'd0, req_ready}, 32'd1);
    chk("r1_rd_data_c3", {16'd0, rd_data}, 32'hBEEF);
    step();
    chk("r1_done_c4", {31'd0, done}, 32'd0);
    rd_override = 1'b0;

    // Wrapping read burst
    push_reads(19'h7FFFE, 4);
    issue(1'b0, 19'h7FFFE, 8'd3);
    ea = 19'h7FFFE;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_read", {31'd0, ctrl_read}, 32'd1);
      chk("wrap_addr", {13'd0, ctrl_addr}, {13'd0, ea});
      ea = ea + 1'b1;
      step(); step(); step();
      chk("wrap_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("wrap_done", {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
    end
    step();

    // Write with stall before the second word
    wr_valid = 1'b1; wr_data = 16'h1234;
    issue(1'b1, 19'h00100, 8'd1);
    chk("w_wr_ready_c0", {31'd0, wr_ready}, 32'd1);
    chk("w_en_c0", {31'd0, ctrl_en}, 32'd0);
    step();
    wr_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk("w1_write", {31'd0, ctrl_write}, 32'd1);
      chk("w1_addr", {13'd0, ctrl_addr}, 32'h100);
      chk("w1_data", {16'd0, ctrl_data_in}, 32'h1234);
      step();
    end
    chk("w1_gap_en", {31'd0, ctrl_en}, 32'd0);
    chk("w1_gap_done", {31'd0, done}, 32'd0);
    step();
    for (int c = 4; c <= 7; c++) begin
      if (c == 7) begin
        wr_valid = 1'b1; wr_data = 16'h5678;
      end
      chk("w2_wdata_dwell", {31'd0, wr_ready}, 32'd1);
      chk("w2_wdata_en", {31'd0, ctrl_en}, 32'd0);
      step();
    end
    wr_valid = 1'b0;
    for (int c = 8; c <= 9; c++) begin
      chk("w2_write", {31'd0, ctrl_write}, 32'd1);
      chk("w2_addr", {13'd0, ctrl_addr}, 32'h101);
      chk("w2_data", {16'd0, ctrl_data_in}, 32'h5678);
      step();
    end
    chk("w2_gap_done", {31'd0, done}, 32'd0);
    step();
    chk("w2_done", {31'd0, done}, 32'd1);
    chk("w2_req_ready", {31'd0, req_ready}, 32'd1);
    step();

    // Back-to-back: read request held while a write completes
    wr_valid = 1'b1; wr_data = 16'hCAFE;
    issue(1'b1, 19'h00200, 8'd0);
    step();
    wr_valid = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h00300; req_len = 8'd0;
    chk("b2b_busy_write", {31'd0, busy}, 32'd1);
    step(); step(); step();
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_ready_at_done", {31'd0, req_ready}, 32'd1);
    push_reads(19'h00300, 1);
    step();
    req_valid = 1'b0;
    chk("b2b_read_next", {31'd0, ctrl_read}, 32'd1);
    chk("b2b_write_off", {31'd0, ctrl_write}, 32'd0);
    chk("b2b_addr", {13'd0, ctrl_addr}, 32'h300);
    step(); step(); step();
    chk("b2b_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("b2b_rd_done", {31'd0, done}, 32'd1);
    step();

    // Reset in the middle of word 2 of a 4-word write
    wr_valid = 1'b1; wr_data = 16'h0F0F;
    issue(1'b1, 19'h00400, 8'd3);
    for (int c = 0; c < 5; c++) step();
    chk("rst_mid_write", {31'd0, ctrl_write}, 32'd1);
    chk("rst_mid_addr", {13'd0, ctrl_addr}, 32'h401);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en_off", {31'd0, ctrl_en}, 32'd0);
    chk("rst_mid_write_off", {31'd0, ctrl_write}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    wr_valid = 1'b0;
    step();
    chk("rst_mid_no_done_a", {31'd0, done}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
      chk("rst_mid_idle", {31'd0, busy}, 32'd0);
      step();
    end
    push_reads(19'h00500, 2);
    issue(1'b0, 19'h00500, 8'd1);
    chk("post_rst_addr", {13'd0, ctrl_addr}, 32'h500);
    step(); step(); step();
    chk("post_rst_rv0", {31'd0, rd_valid}, 32'd1);
    chk("post_rst_addr1", {13'd0, ctrl_addr}, 32'h501);
    step(); step(); step();
    chk("post_rst_rv1", {31'd0, rd_valid}, 32'd1);
    chk("post_rst_done", {31'd0, done}, 32'd1);
    step();

    // Maximum-length read
    push_reads(19'h01000, 256);
    issue(1'b0, 19'h01000, 8'd255);
    pulses = 0; last_addr = '0; seen_done = 1'b0;
    for (int c = 0; c < 900 && !seen_done; c++) begin
      if (ctrl_read) last_addr = ctrl_addr;
      if (rd_valid) pulses++;
      if (done) seen_done = 1'b1;
      if (!seen_done) step();
    end
    chk("max_done_seen", {31'd0, seen_done}, 32'd1);
    chk("max_pulses", pulses, 32'd256);
    chk("max_last_addr", {13'd0, last_addr}, 32'h010FF);
    step(); step();
    chk("scoreboard_empty", rd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
